axi4_a23_sram_slave: RTL and testbench

- AXI4 slave (responder) backed by an on-chip single-port word SRAM; it is the memory end of the a23 core's AXI4 master interface.
- Serves the master's single-beat core reads and writes, and its 4-beat WRAP cache-line fills.
- Handles one outstanding read and one outstanding write.
- The read and write channels arbitrate for the single memory port.

---
 rtl/axi4_a23_slave_pkg.sv | 49 ++++
 rtl/axi4_if.sv | 69 ++++++
 rtl/axi4_a23_sram_array.sv | 38 +++
 rtl/axi4_a23_sram_slave.sv | 191 +++++++++++++++++++
 tb/tb_axi4_a23_sram_slave.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_a23_slave_pkg.sv
// axi4_a23_slave_pkg : burst/response constants, FSM state types, beat address helper
// rev 1.0
`default_nettype none

package axi4_a23_slave_pkg;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_MEM  = 2'd1,
    R_DATA = 2'd2
  } read_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } write_state_e;

  function automatic logic [31:0] next_beat_addr(input logic [31:0] addr,
                                                 input logic [7:0]  len,
                                                 input logic [1:0]  burst);
    logic [31:0] mask;
    mask = (({24'd0, len} + 32'd1) << 2) - 32'd1;
    case (burst)
      INCR:    return addr + 32'd4;
      WRAP:    return (addr & ~mask) | ((addr + 32'd4) & mask);
      default: return addr;
    endcase
  endfunction

  // Whole-transaction errors, decided once when the address is accepted.
  function automatic logic bad_xact(input logic [2:0] size,
                                    input logic [7:0] len,
                                    input logic [1:0] burst);
    return (size != 3'd2) ||
           ((burst == WRAP) &&
            !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_if.sv
// axi4_if : AXI4 bundle, 32-bit address/data, parameterised ID width
// rev 1.0
`default_nettype none

interface axi4_if #(
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

`default_nettype wire

// File: rtl/axi4_a23_sram_array.sv
// axi4_a23_sram_array : single-port word SRAM, 4 byte enables, registered read
// rev 1.0
`default_nettype none

module axi4_a23_sram_array #(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [MEM_WORDS];
  logic [31:0] r_rdata;

  // Read register only moves on a read, so it holds a beat while RREADY is low.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/axi4_a23_sram_slave.sv
// axi4_a23_sram_slave : AXI4 responder for the a23 core, single-port SRAM backed
// rev 1.0
`default_nettype none

module axi4_a23_sram_slave
  import axi4_a23_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          ID_WIDTH  = 4
) (
  input  logic  i_clk,
  input  logic  i_rst,
  axi4_if.slave slave
);

  localparam int          c_AW   = $clog2(MEM_WORDS);
  localparam logic [31:0] c_SPAN = 32'(4 * MEM_WORDS);

  function automatic logic f_in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < c_SPAN);
  endfunction

  function automatic logic [c_AW-1:0] f_idx(input logic [31:0] a);
    return c_AW'((a - BASE_ADDR) >> 2);
  endfunction

  read_state_e         r_rstate;
  logic [31:0]         r_raddr;
  logic [7:0]          r_rlen;
  logic [7:0]          r_rcnt;
  logic [1:0]          r_rburst;
  logic                r_rxerr;
  logic                r_rberr;
  logic [ID_WIDTH-1:0] r_rid;

  write_state_e        r_wstate;
  logic [31:0]         r_waddr;
  logic [7:0]          r_wlen;
  logic [7:0]          r_wcnt;
  logic [1:0]          r_wburst;
  logic                r_wxerr;
  logic                r_werr;
  logic [ID_WIDTH-1:0] r_wid;

  logic                r_rd_denied;

  logic w_rd_err, w_rd_req, w_rd_grant, w_rd_go, w_rd_last;
  logic w_wr_busy, w_wready, w_wfire, w_wbeat_err, w_wr_last, w_mem_we, w_mem_en;
  logic [c_AW-1:0] w_mem_addr;
  logic [31:0]     w_mem_rdata;

  // Erroring read beats never touch the SRAM, so they need no grant.
  assign w_rd_last   = (r_rcnt == r_rlen);
  assign w_rd_err    = r_rxerr || !f_in_range(r_raddr);
  assign w_rd_req    = (r_rstate == R_MEM) && !w_rd_err;
  assign w_wr_busy   = (r_wstate == W_DATA) && slave.wvalid;
  assign w_rd_grant  = w_rd_req && (r_rd_denied || !w_wr_busy);
  assign w_rd_go     = (r_rstate == R_MEM) && (w_rd_err || w_rd_grant);

  // Writes own the port unless the read lost last cycle; then WREADY yields.
  assign w_wr_last   = (r_wcnt == r_wlen);
  assign w_wready    = (r_wstate == W_DATA) && !r_rd_denied;
  assign w_wfire     = w_wready && slave.wvalid;
  assign w_wbeat_err = r_wxerr || !f_in_range(r_waddr) || (slave.wlast != w_wr_last);
  assign w_mem_we    = w_wfire && !w_wbeat_err;
  assign w_mem_en    = w_mem_we || w_rd_grant;
  assign w_mem_addr  = w_mem_we ? f_idx(r_waddr) : f_idx(r_raddr);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rd_denied <= 1'b0;
    else       r_rd_denied <= w_rd_req && !w_rd_grant;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rstate <= R_IDLE;
      r_raddr  <= 32'd0;
      r_rlen   <= 8'd0;
      r_rcnt   <= 8'd0;
      r_rburst <= INCR;
      r_rxerr  <= 1'b0;
      r_rberr  <= 1'b0;
      r_rid    <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (slave.arvalid) begin
            r_raddr  <= slave.araddr;
            r_rlen   <= slave.arlen;
            r_rburst <= slave.arburst;
            r_rxerr  <= bad_xact(slave.arsize, slave.arlen, slave.arburst);
            r_rid    <= slave.arid;
            r_rcnt   <= 8'd0;
            r_rstate <= R_MEM;
          end
        end
        R_MEM: begin
          if (w_rd_go) begin
            r_rberr  <= w_rd_err;
            r_rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (slave.rready) begin
            if (w_rd_last) begin
              r_rstate <= R_IDLE;
            end else begin
              r_raddr  <= next_beat_addr(r_raddr, r_rlen, r_rburst);
              r_rcnt   <= r_rcnt + 8'd1;
              r_rstate <= R_MEM;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wstate <= W_IDLE;
      r_waddr  <= 32'd0;
      r_wlen   <= 8'd0;
      r_wcnt   <= 8'd0;
      r_wburst <= INCR;
      r_wxerr  <= 1'b0;
      r_werr   <= 1'b0;
      r_wid    <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (slave.awvalid) begin
            r_waddr  <= slave.awaddr;
            r_wlen   <= slave.awlen;
            r_wburst <= slave.awburst;
            r_wxerr  <= bad_xact(slave.awsize, slave.awlen, slave.awburst);
            r_wid    <= slave.awid;
            r_wcnt   <= 8'd0;
            r_werr   <= 1'b0;
            r_wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_wfire) begin
            r_werr <= r_werr || w_wbeat_err;
            if (w_wr_last) begin
              r_wstate <= W_RESP;
            end else begin
              r_waddr <= next_beat_addr(r_waddr, r_wlen, r_wburst);
              r_wcnt  <= r_wcnt + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (slave.bready) r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  axi4_a23_sram_array #(
    .MEM_WORDS (MEM_WORDS),
    .ADDR_W    (c_AW)
  ) u_array (
    .i_clk   (i_clk),
    .i_en    (w_mem_en),
    .i_we    (w_mem_we),
    .i_be    (slave.wstrb),
    .i_addr  (w_mem_addr),
    .i_wdata (slave.wdata),
    .o_rdata (w_mem_rdata)
  );

  assign slave.arready = (r_rstate == R_IDLE) && !i_rst;
  assign slave.rvalid  = (r_rstate == R_DATA);
  assign slave.rlast   = (r_rstate == R_DATA) && w_rd_last;
  assign slave.rid     = r_rid;
  assign slave.rdata   = ((r_rstate == R_DATA) && !r_rberr) ? w_mem_rdata : 32'd0;
  assign slave.rresp   = ((r_rstate == R_DATA) && r_rberr) ? SLVERR : OKAY;

  assign slave.awready = (r_wstate == W_IDLE) && !i_rst;
  assign slave.wready  = w_wready;
  assign slave.bvalid  = (r_wstate == W_RESP);
  assign slave.bid     = r_wid;
  assign slave.bresp   = ((r_wstate == W_RESP) && r_werr) ? SLVERR : OKAY;

endmodule

`default_nettype wire

// File: tb/tb_axi4_a23_sram_slave.sv
// tb_axi4_a23_sram_slave : directed bench for axi4_a23_sram_slave
// rev 1.0
`default_nettype none

module tb_axi4_a23_sram_slave
  import axi4_a23_slave_pkg::*;
;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4_if #(.ID_WIDTH(4)) axi ();

  axi4_a23_sram_slave #(
    .BASE_ADDR (32'h0000_0000),
    .MEM_WORDS (1024),
    .ID_WIDTH  (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .slave (axi)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  wr_bresp;
  logic [3:0]  wr_bid;
  logic [31:0] rb_data [16];
  logic [1:0]  rb_resp [16];
  logic [15:0] rb_last;
  logic [3:0]  rb_id;
  int          rb_n;
  int          rb_lat;
  logic        rb_stable;

  task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [2:0] sz, input logic [3:0] id);
    int k;
    axi.awaddr = a; axi.awlen = 8'd0; axi.awburst = INCR; axi.awsize = sz; axi.awid = id;
    axi.awvalid = 1'b1;
    k = 0;
    while (!axi.awready && k < 50) begin tick(); k++; end
    if (!axi.awready) chk("aw_timeout", 0, 1);
    tick();
    axi.awvalid = 1'b0;
    axi.wdata = d; axi.wstrb = s; axi.wlast = 1'b1; axi.wvalid = 1'b1;
    k = 0;
    while (!axi.wready && k < 50) begin tick(); k++; end
    if (!axi.wready) chk("w_timeout", 0, 1);
    tick();
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    axi.bready = 1'b1;
    k = 0;
    while (!axi.bvalid && k < 50) begin tick(); k++; end
    if (!axi.bvalid) chk("b_timeout", 0, 1);
    wr_bresp = axi.bresp;
    wr_bid   = axi.bid;
    tick();
    axi.bready = 1'b0;
  endtask

  // hold > 0 keeps RREADY low for that many extra cycles on the first beat.
  task automatic rd(input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst,
                    input logic [2:0] sz, input logic [3:0] id, input int hold);
    int k;
    logic [31:0] d0;
    logic        l0;
    logic [1:0]  r0;
    axi.araddr = a; axi.arlen = len; axi.arburst = burst; axi.arsize = sz; axi.arid = id;
    axi.arvalid = 1'b1;
    axi.rready  = (hold == 0);
    rb_n = 0; rb_last = '0; rb_stable = 1'b1;
    k = 0;
    while (!axi.arready && k < 50) begin tick(); k++; end
    if (!axi.arready) chk("ar_timeout", 0, 1);
    tick();
    axi.arvalid = 1'b0;
    rb_lat = 1;
    while (!axi.rvalid && rb_lat < 50) begin tick(); rb_lat++; end
    while (rb_n <= int'(len) && rb_n < 16) begin
      k = 0;
      while (!axi.rvalid && k < 50) begin tick(); k++; end
      if (!axi.rvalid) begin
        chk("r_timeout", 0, 1);
        axi.rready = 1'b1;
        return;
      end
      if (rb_n == 0 && hold > 0) begin
        d0 = axi.rdata; l0 = axi.rlast; r0 = axi.rresp;
        repeat (hold) begin
          tick();
          if (axi.rdata !== d0 || axi.rlast !== l0 || axi.rresp !== r0 || !axi.rvalid)
            rb_stable = 1'b0;
        end
        axi.rready = 1'b1;
      end
      rb_data[rb_n] = axi.rdata;
      rb_resp[rb_n] = axi.rresp;
      rb_last[rb_n] = axi.rlast;
      rb_id = axi.rid;
      rb_n++;
      tick();
    end
    axi.rready = 1'b1;
  endtask

  logic [5:0]  rv_seen;
  logic [5:0]  wr_seen;
  logic [31:0] c_rdat;
  int          wb;
  logic        ar_hs, w_hs;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'd2; axi.awburst = INCR;
    axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'd2;
    axi.arburst = INCR; axi.arvalid = 1'b0; axi.rready = 1'b1;
    repeat (3) tick();

    chk("rst_arready", 32'(axi.arready), 0);
    chk("rst_awready", 32'(axi.awready), 0);
    chk("rst_wready",  32'(axi.wready),  0);
    chk("rst_rvalid",  32'(axi.rvalid),  0);
    chk("rst_rlast",   32'(axi.rlast),   0);
    chk("rst_bvalid",  32'(axi.bvalid),  0);
    chk("rst_resps",   32'({axi.rresp, axi.bresp}), 0);
    chk("rst_rdata",   axi.rdata, 0);
    rst = 1'b0;
    #1;
    chk("idle_arready", 32'(axi.arready), 1);
    chk("idle_awready", 32'(axi.awready), 1);

    wr1(32'h100, 32'hDEAD_BEEF, 4'hF, 3'd2, 4'd1);
    chk("pre_bresp", 32'(wr_bresp), 32'(OKAY));
    wr1(32'h104, 32'hA0A0_A004, 4'hF, 3'd2, 4'd1);
    wr1(32'h108, 32'hA0A0_A008, 4'hF, 3'd2, 4'd1);
    wr1(32'h10C, 32'hA0A0_A00C, 4'hF, 3'd2, 4'd1);
    wr1(32'h200, 32'h0000_0000, 4'hF, 3'd2, 4'd1);

    rd(32'h100, 8'd0, INCR, 3'd2, 4'd5, 0);
    chk("rd1_latency", rb_lat, 2);
    chk("rd1_data", rb_data[0], 32'hDEAD_BEEF);
    chk("rd1_last", 32'(rb_last), 1);
    chk("rd1_resp", 32'(rb_resp[0]), 32'(OKAY));
    chk("rd1_rid", 32'(rb_id), 5);

    rd(32'h108, 8'd3, WRAP, 3'd2, 4'd3, 0);
    chk("fill_beats", rb_n, 4);
    chk("fill_b0", rb_data[0], 32'hA0A0_A008);
    chk("fill_b1", rb_data[1], 32'hA0A0_A00C);
    chk("fill_b2", rb_data[2], 32'hDEAD_BEEF);
    chk("fill_b3", rb_data[3], 32'hA0A0_A004);
    chk("fill_last", 32'(rb_last), 32'h8);
    chk("fill_resp", 32'({rb_resp[0], rb_resp[1], rb_resp[2], rb_resp[3]}), 0);

    wr1(32'h200, 32'h1122_3344, 4'b0101, 3'd2, 4'd9);
    chk("bw_bresp", 32'(wr_bresp), 32'(OKAY));
    chk("bw_bid", 32'(wr_bid), 9);
    rd(32'h200, 8'd0, INCR, 3'd2, 4'd0, 0);
    chk("bw_readback", rb_data[0], 32'h0022_0044);

    rd(32'h1000, 8'd0, INCR, 3'd2, 4'd2, 0);
    chk("oor_resp", 32'(rb_resp[0]), 32'(SLVERR));
    chk("oor_data", rb_data[0], 0);

    wr1(32'h200, 32'hFFFF_FFFF, 4'hF, 3'd1, 4'd6);
    chk("sz_bresp", 32'(wr_bresp), 32'(SLVERR));
    rd(32'h200, 8'd0, INCR, 3'd2, 4'd0, 0);
    chk("sz_mem_kept", rb_data[0], 32'h0022_0044);

    rd(32'h100, 8'd2, WRAP, 3'd2, 4'd4, 0);
    chk("wrap2_beats", rb_n, 3);
    chk("wrap2_last", 32'(rb_last), 32'h4);
    for (int i = 0; i < 3; i++) begin
      chk("wrap2_resp", 32'(rb_resp[i]), 32'(SLVERR));
      chk("wrap2_data", rb_data[i], 0);
    end

    // Read pending while a 4-beat write streams continuously.
    axi.awaddr = 32'h300; axi.awlen = 8'd3; axi.awburst = INCR; axi.awsize = 3'd2;
    axi.awid = 4'd1; axi.awvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0;
    axi.araddr = 32'h100; axi.arlen = 8'd0; axi.arburst = INCR; axi.arsize = 3'd2;
    axi.arid = 4'd2; axi.arvalid = 1'b1; axi.rready = 1'b1;
    wb = 0; axi.wdata = 32'h3000_0000; axi.wstrb = 4'hF; axi.wlast = 1'b0; axi.wvalid = 1'b1;
    c_rdat = '0;
    for (int c = 0; c < 6; c++) begin
      wr_seen[c] = axi.wready;
      rv_seen[c] = axi.rvalid;
      if (axi.rvalid) c_rdat = axi.rdata;
      ar_hs = axi.arvalid && axi.arready;
      w_hs  = axi.wvalid && axi.wready;
      tick();
      if (ar_hs) axi.arvalid = 1'b0;
      if (w_hs) begin
        wb++;
        if (wb == 4) begin
          axi.wvalid = 1'b0; axi.wlast = 1'b0;
        end else begin
          axi.wdata = 32'h3000_0000 + 32'(wb);
          axi.wlast = (wb == 3);
        end
      end
    end
    chk("cont_wready", 32'(wr_seen[4:0]), 32'b11011);
    chk("cont_rvalid", 32'(rv_seen), 32'b001000);
    chk("cont_rdata", c_rdat, 32'hDEAD_BEEF);
    axi.bready = 1'b1;
    begin
      int k;
      k = 0;
      while (!axi.bvalid && k < 50) begin tick(); k++; end
    end
    chk("cont_bvalid", 32'(axi.bvalid), 1);
    chk("cont_bresp", 32'(axi.bresp), 32'(OKAY));
    tick();
    axi.bready = 1'b0;
    rd(32'h300, 8'd3, INCR, 3'd2, 4'd0, 0);
    for (int i = 0; i < 4; i++) chk("cont_mem", rb_data[i], 32'h3000_0000 + 32'(i));

    rd(32'h108, 8'd1, INCR, 3'd2, 4'd2, 5);
    chk("bp_stable", 32'(rb_stable), 1);
    chk("bp_b0", rb_data[0], 32'hA0A0_A008);
    chk("bp_b1", rb_data[1], 32'hA0A0_A00C);
    chk("bp_last", 32'(rb_last), 32'h2);

    // Reset lands while beat 2 of a line fill is on the bus.
    axi.araddr = 32'h108; axi.arlen = 8'd3; axi.arburst = WRAP; axi.arsize = 3'd2;
    axi.arid = 4'd7; axi.arvalid = 1'b1; axi.rready = 1'b1;
    tick();
    axi.arvalid = 1'b0;
    begin
      int k;
      k = 0;
      while (!axi.rvalid && k < 50) begin tick(); k++; end
      tick();
      k = 0;
      while (!axi.rvalid && k < 50) begin tick(); k++; end
    end
    chk("mid_beat2_valid", 32'(axi.rvalid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rvalid", 32'(axi.rvalid), 0);
    chk("mid_arready", 32'(axi.arready), 1);
    rd(32'h104, 8'd0, INCR, 3'd2, 4'd4, 0);
    chk("mid_after_data", rb_data[0], 32'hA0A0_A004);
    chk("mid_after_resp", 32'(rb_resp[0]), 32'(OKAY));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
